// File: rtl/conv1d_pkg.sv
// Shared data width, state encodings and MAC operand payload for the conv1d feeder.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package conv1d_pkg;

    localparam int unsigned W  = `WIDTH_DATA;
    localparam int unsigned PW = 2 * W;

    localparam logic [1:0] ENC_FILL   = 2'd0;
    localparam logic [1:0] ENC_ACCUM  = 2'd1;
    localparam logic [1:0] ENC_OUTPUT = 2'd2;

    typedef enum logic [1:0] {
        ST_FILL   = ENC_FILL,
        ST_ACCUM  = ENC_ACCUM,
        ST_OUTPUT = ENC_OUTPUT
    } state_t;

    // Operands presented to the external MAC for one tap.
    typedef struct packed {
        logic [W-1:0]  weight;
        logic [W-1:0]  feature;
        logic [PW-1:0] psum;
    } mac_req_t;

endpackage

// File: rtl/conv1d_window.sv
// KSIZE-deep feature shift register; win[0] holds the oldest sample.
module conv1d_window
    import conv1d_pkg::*;
#(
    parameter int unsigned KSIZE = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_en,
    input  logic [W-1:0]            din,
    output logic [KSIZE-1:0][W-1:0] win
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < int'(KSIZE) - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[KSIZE-1] <= din;
        end
    end

endmodule

// File: rtl/conv1d_feeder.sv
// Feeds a stride-1 convolution window and kernel taps to an external MAC one tap
// per cycle and returns each accumulated dot product on a valid/ready stream.
module conv1d_feeder
    import conv1d_pkg::*;
#(
    parameter int unsigned KSIZE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_wr_en,
    input  logic [$clog2(KSIZE)-1:0] w_wr_addr,
    input  logic [W-1:0]             w_wr_data,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [W-1:0]             feat_data,
    input  logic                     feat_last,
    output logic [W-1:0]             mac_weight,
    output logic [W-1:0]             mac_feature,
    output logic [PW-1:0]            mac_psum_in,
    input  logic [PW-1:0]            mac_psum_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PW-1:0]            out_data
);

    localparam int unsigned AW = $clog2(KSIZE);
    localparam int unsigned CW = $clog2(KSIZE + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           count;
    logic [AW-1:0]           tap;
    logic [PW-1:0]           acc;
    logic                    last_seen;
    logic [KSIZE-1:0][W-1:0] weights;
    logic [KSIZE-1:0][W-1:0] win;
    mac_req_t                mac_req_c;
    logic                    accept_c;
    logic                    fill_done_c;
    logic                    tap_done_c;
    logic                    out_hs_c;

    assign accept_c    = (state == ST_FILL) && feat_valid;
    assign fill_done_c = accept_c && ((count + CW'(1)) == CW'(KSIZE));
    assign tap_done_c  = (state == ST_ACCUM) && (tap == AW'(KSIZE - 1));
    assign out_hs_c    = (state == ST_OUTPUT) && out_ready;

    conv1d_window #(
        .KSIZE (KSIZE)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept_c),
        .din      (feat_data),
        .win      (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stream ready and MAC operand selection.
    always_comb begin
        state_nxt  = state;
        feat_ready = 1'b0;
        mac_req_c  = '0;
        case (state)
            ST_FILL: begin
                feat_ready = 1'b1;
                if (fill_done_c) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                mac_req_c.weight  = weights[tap];
                mac_req_c.feature = win[tap];
                mac_req_c.psum    = (tap == AW'(0)) ? '0 : acc;
                if (tap_done_c) begin
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    assign mac_weight  = mac_req_c.weight;
    assign mac_feature = mac_req_c.feature;
    assign mac_psum_in = mac_req_c.psum;

    // Fill count, tap walk, accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            last_seen <= 1'b0;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept_c) begin
                if (fill_done_c) begin
                    count     <= CW'(KSIZE);
                    last_seen <= feat_last;
                end else if (feat_last) begin
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end
            if (state == ST_ACCUM) begin
                acc <= mac_psum_out;
                tap <= tap_done_c ? '0 : tap + AW'(1);
            end
            if (tap_done_c) begin
                out_valid <= 1'b1;
                out_data  <= mac_psum_out;
            end else if (out_hs_c) begin
                out_valid <= 1'b0;
                // Stride 1 keeps the newest KSIZE-1 samples unless the sequence ended.
                count     <= last_seen ? '0 : CW'(KSIZE - 1);
            end
        end
    end

    // Kernel is frozen while a dot product is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights <= '0;
        end else if (w_wr_en && (state != ST_ACCUM) && (32'(w_wr_addr) < KSIZE)) begin
            weights[w_wr_addr] <= w_wr_data;
        end
    end

endmodule

// File: doc/conv1d_feeder.md
CONV1D_FEEDER -- requirements
Module: conv1d_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL take data width from the shared define `WIDTH_DATA (W below), with parameter KSIZE, default 3, number of kernel taps (2..16).
REQ-003 w_wr_en input 1: weight write strobe.
REQ-004 w_wr_addr input clog2(KSIZE): tap index written.
REQ-005 w_wr_data input W: weight value.
REQ-006 feat_valid input 1 / feat_ready output 1: feature stream handshake.
REQ-007 feat_data input W: feature sample.
REQ-008 feat_last input 1: marks the final sample of a sequence.
REQ-009 mac_weight output W / mac_feature output W / mac_psum_in output 2W: operands driven to the downstream MAC.
REQ-010 mac_psum_out input 2W: combinational MAC result returned.
REQ-011 out_valid output 1 / out_ready input 1 / out_data output 2W: result stream handshake.

Function
REQ-012 The block SHALL implement states FILL, ACCUM and OUTPUT.
REQ-013 FILL: feat_ready=1; a feature SHALL be accepted on feat_valid&feat_ready and shifted into a KSIZE-deep window (win[0] oldest); fill count saturates at KSIZE.
REQ-014 When an accepted feature makes the count equal KSIZE, the block SHALL go to ACCUM on the next cycle, with tap counter t=0.
REQ-015 ACCUM: feat_ready=0; each cycle mac_weight=w[t], mac_feature=win[t], mac_psum_in = 0 if t==0 else acc; acc<=mac_psum_out; t increments.
REQ-016 After the cycle with t=KSIZE-1, the block SHALL go to OUTPUT; latency from the completing feature handshake to out_valid SHALL be exactly KSIZE+1 cycles.
REQ-017 OUTPUT: out_valid=1, out_data=acc held stable until out_ready; on handshake go to FILL.
REQ-018 Stride is 1: after an output the window SHALL keep its last KSIZE-1 samples (count=KSIZE-1), so each further feature yields one output.
REQ-019 If the feature that completed the window had feat_last=1, the count SHALL clear to 0 on the output handshake (next sequence starts empty).
REQ-020 If feat_last is accepted with count<KSIZE after the shift, the block SHALL clear the count to 0 and produce no output.
REQ-021 Arithmetic SHALL be unsigned and acc SHALL wrap modulo 2^(2W).
REQ-022 Weight writes SHALL take effect the next cycle in FILL and OUTPUT, and SHALL be ignored in ACCUM.
REQ-023 Outside ACCUM, mac_weight, mac_feature and mac_psum_in SHALL be 0.

Reset
REQ-024 On rst_n=0, the block SHALL immediately set state=FILL, count=0, t=0, acc=0, all weights and window entries 0, out_valid=0, out_data=0, mac_* outputs 0; feat_ready=1 after release.
REQ-025 Reset asserted mid-ACCUM or mid-OUTPUT SHALL discard the partial or pending result; no out_valid follows release until a full new window is accepted.

Structure
REQ-026 WIDTH_DATA SHALL remain in the shared define file; state encodings SHALL be localparams in a shared conv1d package/define.
REQ-027 The window shift register SHALL be one sub-module, conv1d_window; the MAC SHALL stay external.

Verification
REQ-028 KSIZE=3, weights {1,2,3}, features 1,2,3,4 with MAC connected, out_ready=1 -> out_data 14, then 20; first out_valid 4 cycles after feature 3.
REQ-029 Hold out_ready=0 for 5 cycles in OUTPUT -> out_data stable, feat_ready=0, no feature consumed; release -> single handshake.
REQ-030 W=8, all weights 255, features 255,255,255 -> out_data 64003 (wrap mod 65536).
REQ-031 Features 5,6 with feat_last on 6 -> no output; the next sequence 1,2,3 -> 14.
REQ-032 Write w[0]=9 during ACCUM -> current result unchanged; the same write in FILL -> next result uses 9.
REQ-033 Assert rst_n=0 at t=1 of ACCUM -> all outputs 0 immediately; no out_valid until 3 new features are accepted.
